mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single combinational-read memory.
// Each access runs IDLE -> ACCESS -> DONE; ack/err/rdata are registered at the ACCESS->DONE edge.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter logic [15:0] MEM_ADDR = 16'h1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [1:0]  p0_size,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_ack,
    output logic        p0_err,
    output logic [31:0] p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [1:0]  p1_size,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_ack,
    output logic        p1_err,
    output logic [31:0] p1_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_size,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        last_grant;
    logic        grant;
    logic        win;
    logic        cap_we;
    logic [1:0]  cap_size;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic        legal;
    logic [31:0] rd_val;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        win = 1'b0;
        if (p0_req && p1_req) begin
            win = ~last_grant;
        end else if (p1_req) begin
            win = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (p0_req || p1_req) state_next = ACCESS;
            ACCESS:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        legal = 1'b0;
        if (cap_addr[31:16] == MEM_ADDR) begin
            case (cap_size)
                2'd0:    legal = 1'b1;
                2'd1:    legal = ~cap_addr[0];
                2'd3:    legal = (cap_addr[1:0] == 2'b00);
                default: legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_size  = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        if (state == ACCESS) begin
            mem_addr  = cap_addr;
            mem_wdata = cap_wdata;
            mem_size  = cap_size;
            mem_we    = cap_we & legal & ~reset;
            mem_re    = ~cap_we & legal & ~reset;
        end
    end

    assign rd_val = (legal && !cap_we) ? mem_rdata : '0;
    assign busy   = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= 1'b1;
            grant      <= 1'b0;
            cap_we     <= 1'b0;
            cap_size   <= '0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            p0_ack     <= 1'b0;
            p1_ack     <= 1'b0;
            p0_err     <= 1'b0;
            p1_err     <= 1'b0;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
        end else begin
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;
            p0_err <= 1'b0;
            p1_err <= 1'b0;
            if (state == IDLE && (p0_req || p1_req)) begin
                grant      <= win;
                last_grant <= win;
                cap_we     <= win ? p1_we    : p0_we;
                cap_size   <= win ? p1_size  : p0_size;
                cap_addr   <= win ? p1_addr  : p0_addr;
                cap_wdata  <= win ? p1_wdata : p0_wdata;
            end
            if (state == ACCESS) begin
                if (grant) begin
                    p1_ack   <= 1'b1;
                    p1_err   <= ~legal;
                    p1_rdata <= rd_val;
                end else begin
                    p0_ack   <= 1'b1;
                    p0_err   <= ~legal;
                    p0_rdata <= rd_val;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized two-port traffic.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam logic [15:0] REGION = 16'h1000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        p0_req = 1'b0, p0_we = 1'b0;
    logic [1:0]  p0_size = '0;
    logic [31:0] p0_addr = '0, p0_wdata = '0;
    logic        p1_req = 1'b0, p1_we = 1'b0;
    logic [1:0]  p1_size = '0;
    logic [31:0] p1_addr = '0, p1_wdata = '0;
    logic        p0_ack, p0_err, p1_ack, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_size;
    logic        mem_we, mem_re, busy;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    logic [31:0] dev_mem [16];
    logic [31:0] ref_mem [16];

    mem_arbiter #(.MEM_ADDR(REGION)) dut (
        .clock(clock), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] init_val(int i);
        return 32'hC0DE0000 + 32'(i) * 32'h00010001;
    endfunction

    function automatic bit legal_f(logic [1:0] s, logic [31:0] a);
        if ((a >> 16) != 32'(REGION)) return 1'b0;
        case (s)
            2'd0:    return 1'b1;
            2'd1:    return (a % 2) == 0;
            2'd3:    return (a % 4) == 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Bench-side memory: combinational read, written when the DUT strobes mem_we.
    assign mem_rdata = dev_mem[mem_addr[5:2]];
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) dev_mem[i] <= init_val(i);
        end else if (mem_we) begin
            dev_mem[mem_addr[5:2]] <= mem_wdata;
        end
    end

    // Reference model: one pending transaction and a count of cycles until it retires.
    int          m_left;
    bit          m_last, m_port, m_we;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_rd [2];

    always @(posedge clock) begin : model
        bit p;
        bit lg;
        if (reset) begin
            m_left <= 0;
            m_last <= 1'b1;
            m_port <= 1'b0;
            m_we   <= 1'b0;
            m_size <= '0;
            m_addr <= '0;
            m_wdata <= '0;
            m_rd[0] <= '0;
            m_rd[1] <= '0;
            for (int i = 0; i < 16; i++) ref_mem[i] <= init_val(i);
        end else if (m_left == 0) begin
            if (p0_req || p1_req) begin
                p = (p0_req && p1_req) ? !m_last : p1_req;
                m_port  <= p;
                m_last  <= p;
                m_we    <= p ? p1_we    : p0_we;
                m_size  <= p ? p1_size  : p0_size;
                m_addr  <= p ? p1_addr  : p0_addr;
                m_wdata <= p ? p1_wdata : p0_wdata;
                m_left  <= 2;
            end
        end else if (m_left == 2) begin
            lg = legal_f(m_size, m_addr);
            if (lg && m_we) ref_mem[m_addr[5:2]] <= m_wdata;
            m_rd[m_port] <= (lg && !m_we) ? ref_mem[m_addr[5:2]] : 32'h0;
            m_left <= 1;
        end else begin
            m_left <= 0;
        end
    end

    always @(negedge clock) begin
        bit acc;
        bit lg;
        bit dn;
        if (chk_en) begin
            acc = (m_left == 2);
            dn  = (m_left == 1);
            lg  = legal_f(m_size, m_addr);
            chk("busy",      32'(busy),      32'(m_left != 0));
            chk("mem_addr",  mem_addr,       acc ? m_addr  : 32'h0);
            chk("mem_wdata", mem_wdata,      acc ? m_wdata : 32'h0);
            chk("mem_size",  32'(mem_size),  acc ? 32'(m_size) : 32'h0);
            chk("mem_we",    32'(mem_we),    32'(acc && lg && m_we && !reset));
            chk("mem_re",    32'(mem_re),    32'(acc && lg && !m_we && !reset));
            chk("p0_ack",    32'(p0_ack),    32'(dn && !m_port));
            chk("p0_err",    32'(p0_err),    32'(dn && !m_port && !lg));
            chk("p1_ack",    32'(p1_ack),    32'(dn && m_port));
            chk("p1_err",    32'(p1_err),    32'(dn && m_port && !lg));
            chk("p0_rdata",  p0_rdata,       m_rd[0]);
            chk("p1_rdata",  p1_rdata,       m_rd[1]);
        end
    end

    task automatic set_req(input bit port, input bit req, input bit we, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            p1_req = req; p1_we = we; p1_size = size; p1_addr = addr; p1_wdata = wdata;
        end else begin
            p0_req = req; p0_we = we; p0_size = size; p0_addr = addr; p0_wdata = wdata;
        end
    endtask

    // Single-requester access started in IDLE; leaves the arbiter back in IDLE.
    task automatic issue(input string tag, input bit port, input bit we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input bit exp_err, input logic [31:0] exp_rd);
        int n;
        set_req(port, 1'b1, we, size, addr, wdata);
        @(posedge clock); #1;
        chk({tag, "_mem_addr"}, mem_addr, addr);
        chk({tag, "_mem_size"}, 32'(mem_size), 32'(size));
        chk({tag, "_mem_we"},   32'(mem_we), 32'(we && !exp_err));
        chk({tag, "_mem_re"},   32'(mem_re), 32'(!we && !exp_err));
        n = 1;
        while (!(port ? p1_ack : p0_ack) && n < 10) begin
            @(posedge clock); #1;
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd2);
        chk({tag, "_err"},   32'(port ? p1_err : p0_err), 32'(exp_err));
        chk({tag, "_rdata"}, port ? p1_rdata : p0_rdata, exp_rd);
        set_req(port, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        @(posedge clock); #1;
    endtask

    task automatic rand_req(input bit port);
        logic [15:0] hi;
        logic [3:0]  idx;
        logic [1:0]  off;
        hi  = ($urandom_range(0, 5) == 0) ? 16'h2000 : REGION;
        idx = 4'($urandom_range(0, 15));
        off = 2'($urandom_range(0, 3));
        set_req(port, 1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                {hi, 10'h0, idx, off}, $urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int extra;
        bit who;

        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        chk_en = 1'b1;
        chk("rst_busy",     32'(busy),   32'd0);
        chk("rst_p0_ack",   32'(p0_ack), 32'd0);
        chk("rst_p1_ack",   32'(p1_ack), 32'd0);
        chk("rst_p0_rdata", p0_rdata,    32'h0);
        chk("rst_p1_rdata", p1_rdata,    32'h0);
        chk("rst_mem_we",   32'(mem_we), 32'd0);

        // Both ports held high from reset: strict alternation starting at p0.
        set_req(1'b0, 1'b1, 1'b0, 2'd3, 32'h1000_0000, 32'h0);
        set_req(1'b1, 1'b1, 1'b0, 2'd3, 32'h1000_0004, 32'h0);
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                @(posedge clock); #1;
                n++;
            end while (!(p0_ack || p1_ack) && n < 10);
            who = p1_ack;
            chk("rr_order", 32'(who), 32'(k % 2));
            chk("rr_gap", 32'(n), (k == 0) ? 32'd2 : 32'd3);
        end
        set_req(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        set_req(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        @(posedge clock); #1;

        issue("wr_word", 1'b0, 1'b1, 2'd3, 32'h1000_0040, 32'hDEAD_BEEF, 1'b0, 32'h0);
        issue("rd_word", 1'b0, 1'b0, 2'd3, 32'h1000_0040, 32'h0,         1'b0, 32'hDEAD_BEEF);
        chk("model_rd0", m_rd[0], 32'hDEAD_BEEF);

        issue("p1_byte", 1'b1, 1'b1, 2'd0, 32'h1000_0043, 32'h0000_00A5, 1'b0, 32'h0);
        chk("model_byte_mem", ref_mem[0], 32'h0000_00A5);

        issue("bad_region", 1'b0, 1'b1, 2'd3, 32'h2000_0000, 32'h1234_5678, 1'b1, 32'h0);
        issue("bad_size2",  1'b0, 1'b0, 2'd2, 32'h1000_0000, 32'h0,         1'b1, 32'h0);
        issue("bad_half",   1'b0, 1'b0, 2'd1, 32'h1000_0001, 32'h0,         1'b1, 32'h0);

        // p0 won last, so without the reset a tie would go to p1.
        set_req(1'b0, 1'b1, 1'b0, 2'd3, 32'h1000_0000, 32'h0);
        @(posedge clock); #1;
        chk("rst_acc_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;
        chk("rst_acc_busy_after", 32'(busy),   32'd0);
        chk("rst_acc_no_ack",     32'(p0_ack), 32'd0);
        set_req(1'b0, 1'b1, 1'b0, 2'd3, 32'h1000_0000, 32'h0);
        set_req(1'b1, 1'b1, 1'b0, 2'd3, 32'h1000_0004, 32'h0);
        n = 0;
        do begin
            @(posedge clock); #1;
            n++;
        end while (!(p0_ack || p1_ack) && n < 10);
        chk("tie_after_rst_p0", 32'(p0_ack), 32'd1);
        chk("tie_after_rst_p1", 32'(p1_ack), 32'd0);
        chk("tie_after_rst_lat", 32'(n), 32'd2);
        set_req(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        set_req(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        @(posedge clock); #1;

        // p1 withdraws during ACCESS: access still completes, nothing follows.
        set_req(1'b1, 1'b1, 1'b1, 2'd3, 32'h1000_0008, 32'h5555_AAAA);
        @(posedge clock); #1;
        set_req(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        @(posedge clock); #1;
        chk("drop_p1_ack", 32'(p1_ack), 32'd1);
        extra = 0;
        repeat (5) begin
            @(posedge clock); #1;
            if (p0_ack || p1_ack || busy) extra++;
        end
        chk("drop_no_regrant", 32'(extra), 32'd0);

        for (int c = 0; c < 2000; c++) begin
            @(posedge clock); #1;
            if (p0_req && p0_ack) p0_req = 1'b0;
            if (p1_req && p1_ack) p1_req = 1'b0;
            if (p0_req && !p0_ack && $urandom_range(0, 63) == 0) p0_req = 1'b0;
            if (p1_req && !p1_ack && $urandom_range(0, 63) == 0) p1_req = 1'b0;
            if (!p0_req && $urandom_range(0, 2) == 0) rand_req(1'b0);
            if (!p1_req && $urandom_range(0, 2) == 0) rand_req(1'b1);
        end
        set_req(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        set_req(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        repeat (5) @(posedge clock);
        @(negedge clock);
        #1;
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
